// File: rtl/mdio_sniffer_pkg.sv
// Shared encodings and field geometry for the Clause-22 MDIO frame tracker.
package mdio_sniffer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;
  localparam int TA_LEN  = 2;

  localparam logic [5:0] ONES_MAX = 6'd63;

endpackage

// File: rtl/mdio_sniffer_sync_edge.sv
// Two-FF synchroniser for an edge-detected pin plus W data pins, all with equal latency.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         edge_d,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise,
  output logic         fall
);

  logic         edge_s1;
  logic         edge_s2;
  logic         hist;
  logic [W-1:0] d_s1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_s1 <= 1'b0;
      edge_s2 <= 1'b0;
      hist    <= 1'b0;
      d_s1    <= '0;
      q       <= '0;
    end else begin
      edge_s1 <= edge_d;
      edge_s2 <= edge_s1;
      hist    <= edge_s2;
      d_s1    <= d;
      q       <= d_s1;
    end
  end

  assign rise = edge_s2 & ~hist;
  assign fall = ~edge_s2 & hist;

endmodule

// File: rtl/mdio_sniffer.sv
// Clause-22 MDIO frame tracker: steers the MDIO buffer direction and reports decoded frames.
module mdio_sniffer
  import mdio_sniffer_pkg::*;
#(
  parameter int C_min_preamble = 32,
  parameter int C_timeout_bits = 10
) (
  input  logic                clk_25mhz,
  input  logic                rstn,
  input  logic                mdc,
  input  logic                mdio_wifi,
  input  logic                mdio_phy,
  output logic                mdio_read,
  output logic                frame_valid,
  output logic                frame_op,
  output logic [PHYAD_W-1:0]  frame_phyad,
  output logic [REGAD_W-1:0]  frame_regad,
  output logic [DATA_W-1:0]   frame_data,
  output logic                frame_ta_err,
  output logic                busy
);

  logic [1:0] mdio_q;
  logic       rise;
  logic       fall;

  sync_edge #(.W(2)) u_sync (
    .clk    (clk_25mhz),
    .rstn   (rstn),
    .edge_d (mdc),
    .d      ({mdio_phy, mdio_wifi}),
    .q      (mdio_q),
    .rise   (rise),
    .fall   (fall)
  );

  state_t               state, state_nx;
  logic [4:0]           cnt, cnt_nx;
  logic [5:0]           ones, ones_nx;
  logic [C_timeout_bits:0] tmo;
  logic                 op_rd, op_hi, ta2;
  logic                 pend_on, pend_off;
  logic                 abort, done, last_regad;
  logic                 b;
  logic [PHYAD_W-1:0]   sh_phyad;
  logic [REGAD_W-1:0]   sh_regad;
  logic [DATA_W-1:0]    sh_data;

  // Once the ESP32 has released the line in a read, the PHY's bits are the ones that count.
  assign b = (op_rd && (state == S_TA || state == S_DATA)) ? mdio_q[1] : mdio_q[0];

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ones_nx    = ones;
    abort      = 1'b0;
    done       = 1'b0;
    last_regad = 1'b0;
    if (tmo[C_timeout_bits] && !(rise || fall) && state != S_IDLE) begin
      abort    = 1'b1;
      state_nx = S_IDLE;
      ones_nx  = '0;
      cnt_nx   = '0;
    end else if (rise) begin
      cnt_nx = cnt + 5'd1;
      case (state)
        S_IDLE: begin
          cnt_nx = '0;
          if (b) begin
            if (ones != ONES_MAX) ones_nx = ones + 6'd1;
          end else if (int'(ones) >= C_min_preamble) begin
            state_nx = S_ST;
          end else begin
            ones_nx = '0;
          end
        end
        S_ST: begin
          cnt_nx = '0;
          if (b) state_nx = S_OP;
          else begin
            state_nx = S_IDLE;
            ones_nx  = '0;
          end
        end
        S_OP: if (cnt == 5'd1) begin
          cnt_nx = '0;
          if ({op_hi, b} == OP_READ || {op_hi, b} == OP_WRITE) state_nx = S_PHYAD;
          else begin
            state_nx = S_IDLE;
            ones_nx  = '0;
          end
        end
        S_PHYAD: if (cnt == 5'(PHYAD_W - 1)) begin
          cnt_nx   = '0;
          state_nx = S_REGAD;
        end
        S_REGAD: if (cnt == 5'(REGAD_W - 1)) begin
          cnt_nx     = '0;
          state_nx   = S_TA;
          last_regad = 1'b1;
        end
        S_TA: if (cnt == 5'(TA_LEN - 1)) begin
          cnt_nx   = '0;
          state_nx = S_DATA;
        end
        S_DATA: if (cnt == 5'(DATA_W - 1)) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
          ones_nx  = '0;
          done     = 1'b1;
        end
        default: begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ones         <= '0;
      tmo          <= '0;
      op_rd        <= 1'b0;
      pend_on      <= 1'b0;
      pend_off     <= 1'b0;
      mdio_read    <= 1'b0;
      frame_valid  <= 1'b0;
      frame_op     <= 1'b0;
      frame_phyad  <= '0;
      frame_regad  <= '0;
      frame_data   <= '0;
      frame_ta_err <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ones        <= ones_nx;
      busy        <= (state_nx != S_IDLE);
      frame_valid <= done;
      if (rise || fall) tmo <= '0;
      else if (!tmo[C_timeout_bits]) tmo <= tmo + 1'b1;
      if (rise && state == S_OP && cnt == 5'd1) op_rd <= ({op_hi, b} == OP_READ);
      // Direction flips on the MDC fall after the deciding rise, when the bus owner changes.
      if (abort) pend_on <= 1'b0;
      else if (last_regad && op_rd) pend_on <= 1'b1;
      else if (fall) pend_on <= 1'b0;
      if (abort) pend_off <= 1'b0;
      else if (done && op_rd) pend_off <= 1'b1;
      else if (fall) pend_off <= 1'b0;
      if (abort) mdio_read <= 1'b0;
      else if (fall && pend_on) mdio_read <= 1'b1;
      else if (fall && pend_off) mdio_read <= 1'b0;
      if (done) begin
        frame_op     <= op_rd;
        frame_phyad  <= sh_phyad;
        frame_regad  <= sh_regad;
        frame_data   <= {sh_data[DATA_W-2:0], b};
        frame_ta_err <= op_rd & ta2;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (rise) begin
      case (state)
        S_OP:    if (cnt == 5'd0) op_hi <= b;
        S_PHYAD: sh_phyad <= {sh_phyad[PHYAD_W-2:0], b};
        S_REGAD: sh_regad <= {sh_regad[REGAD_W-2:0], b};
        S_TA:    if (cnt == 5'(TA_LEN - 1)) ta2 <= b;
        S_DATA:  sh_data <= {sh_data[DATA_W-2:0], b};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_sniffer.sv
// Directed bench for mdio_sniffer: bit-level MDIO frames with a scoreboard of expected frames.
module tb_mdio_sniffer;

  logic        clk_25mhz = 1'b0;
  logic        rstn      = 1'b0;
  logic        mdc       = 1'b0;
  logic        mdio_wifi = 1'b1;
  logic        mdio_phy  = 1'b1;
  logic        mdio_read;
  logic        frame_valid;
  logic        frame_op;
  logic [4:0]  frame_phyad;
  logic [4:0]  frame_regad;
  logic [15:0] frame_data;
  logic        frame_ta_err;
  logic        busy;

  mdio_sniffer dut (
    .clk_25mhz    (clk_25mhz),
    .rstn         (rstn),
    .mdc          (mdc),
    .mdio_wifi    (mdio_wifi),
    .mdio_phy     (mdio_phy),
    .mdio_read    (mdio_read),
    .frame_valid  (frame_valid),
    .frame_op     (frame_op),
    .frame_phyad  (frame_phyad),
    .frame_regad  (frame_regad),
    .frame_data   (frame_data),
    .frame_ta_err (frame_ta_err),
    .busy         (busy)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  typedef struct {
    logic        op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] data;
    logic        ta_err;
  } frame_t;

  frame_t exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     frames = 0;
  int     t_mark = 0;
  int     t_mr_rise = 0;
  logic   fv_prev = 1'b0;
  logic   mr_prev = 1'b0;
  logic   mr_seen = 1'b0;
  logic   busy_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_25mhz) cyc++;

  always @(negedge clk_25mhz) begin
    if (rstn && fv_prev) chk("fv_width", {31'd0, frame_valid}, 32'd0);
    if (frame_valid) begin
      frame_t e;
      frames++;
      chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("op",     {31'd0, frame_op},    {31'd0, e.op});
        chk("phyad",  {27'd0, frame_phyad}, {27'd0, e.phyad});
        chk("regad",  {27'd0, frame_regad}, {27'd0, e.regad});
        chk("data",   {16'd0, frame_data},  {16'd0, e.data});
        chk("ta_err", {31'd0, frame_ta_err}, {31'd0, e.ta_err});
      end
    end
    if (mdio_read && !mr_prev) t_mr_rise = cyc;
    if (mdio_read) mr_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    fv_prev = frame_valid;
    mr_prev = mdio_read;
  end

  task automatic send_bit(input logic w, input logic p, input logic mark);
    @(posedge clk_25mhz); #1;
    mdc = 1'b0; mdio_wifi = w; mdio_phy = p;
    if (mark) t_mark = cyc;
    repeat (5) @(posedge clk_25mhz);
    #1 mdc = 1'b1;
    repeat (4) @(posedge clk_25mhz);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad, input logic [15:0] dw, input logic [15:0] dp,
                            input logic ta2, input int nbits, input logic push);
    logic [31:0] w, p;
    logic        rd;
    frame_t      e;
    rd = (op == 2'b10);
    w  = {2'b01, op, phy, regad, rd ? 2'b11 : 2'b10, rd ? 16'hFFFF : dw};
    p  = rd ? {14'h3FFF, 1'b1, ta2, dp} : 32'hFFFF_FFFF;
    if (push) begin
      e.op = rd; e.phyad = phy; e.regad = regad;
      e.data = rd ? dp : dw; e.ta_err = rd & ta2;
      exp_q.push_back(e);
    end
    for (int i = 0; i < npre; i++) send_bit(1'b1, 1'b1, 1'b0);
    for (int i = 31; i >= 32 - nbits; i--) send_bit(w[i], p[i], i == 17);
  endtask

  initial begin
    int f0;
    // Reset state
    repeat (3) @(posedge clk_25mhz);
    #1;
    chk("rst_mdio_read", {31'd0, mdio_read}, 32'd0);
    chk("rst_valid",     {31'd0, frame_valid}, 32'd0);
    chk("rst_op",        {31'd0, frame_op}, 32'd0);
    chk("rst_phyad",     {27'd0, frame_phyad}, 32'd0);
    chk("rst_regad",     {27'd0, frame_regad}, 32'd0);
    chk("rst_data",      {16'd0, frame_data}, 32'd0);
    chk("rst_ta_err",    {31'd0, frame_ta_err}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    repeat (3) @(posedge clk_25mhz);

    // Write frame
    mr_seen = 1'b0;
    send_frame(32, 2'b01, 5'd1, 5'd0, 16'h3100, 16'hFFFF, 1'b1, 32, 1'b1);
    idle_bits(2);
    chk("wr_frames", frames, 1);
    chk("wr_no_read", {31'd0, mr_seen}, 32'd0);

    // Read frame
    send_frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 16'h0007, 1'b0, 32, 1'b1);
    chk("rd_read_hold", {31'd0, mdio_read}, 32'd1);
    chk("rd_on_delay", {31'd0, (t_mr_rise - t_mark) >= 3 && (t_mr_rise - t_mark) <= 4}, 32'd1);
    idle_bits(2);
    chk("rd_read_off", {31'd0, mdio_read}, 32'd0);
    chk("rd_frames", frames, 2);

    // Absent PHY
    send_frame(32, 2'b10, 5'd3, 5'd1, 16'h0000, 16'hFFFF, 1'b1, 32, 1'b1);
    idle_bits(2);
    chk("abs_frames", frames, 3);

    // Short preamble
    busy_seen = 1'b0;
    send_frame(20, 2'b01, 5'd1, 5'd0, 16'h3100, 16'hFFFF, 1'b1, 32, 1'b0);
    idle_bits(2);
    chk("short_frames", frames, 3);
    chk("short_busy", {31'd0, busy_seen}, 32'd0);

    // Illegal op
    mr_seen = 1'b0;
    send_frame(32, 2'b11, 5'd1, 5'd0, 16'h0000, 16'hFFFF, 1'b1, 4, 1'b0);
    idle_bits(2);
    chk("ill_frames", frames, 3);
    chk("ill_no_read", {31'd0, mr_seen}, 32'd0);
    chk("ill_busy", {31'd0, busy}, 32'd0);

    // Timeout abort mid-read
    f0 = frames;
    send_frame(32, 2'b10, 5'd1, 5'd4, 16'h0000, 16'h1234, 1'b0, 21, 1'b0);
    repeat (400) @(posedge clk_25mhz);
    #1;
    chk("tmo_busy_before", {31'd0, busy}, 32'd1);
    chk("tmo_read_before", {31'd0, mdio_read}, 32'd1);
    repeat (630) @(posedge clk_25mhz);
    #1;
    chk("tmo_busy_after", {31'd0, busy}, 32'd0);
    chk("tmo_read_after", {31'd0, mdio_read}, 32'd0);
    chk("tmo_no_pulse", frames, f0);
    chk("tmo_data_hold", {16'd0, frame_data}, 32'h0000FFFF);
    chk("tmo_ta_hold", {31'd0, frame_ta_err}, 32'd1);

    // Reset pulse mid-read
    send_frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 16'h0055, 1'b0, 20, 1'b0);
    repeat (2) @(posedge clk_25mhz);
    #7;
    chk("rst2_read_before", {31'd0, mdio_read}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst2_read", {31'd0, mdio_read}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_data", {16'd0, frame_data}, 32'd0);
    chk("rst2_ta_err", {31'd0, frame_ta_err}, 32'd0);
    repeat (2) @(posedge clk_25mhz);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk_25mhz);
    #1;
    chk("rst2_busy_after", {31'd0, busy}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
